// File: rtl/program_sequencer_pkg.sv
// Shared types for the instruction fetch sequencer: branch condition codes, status flag indices,
// the per-cycle sequencer operation and return-address-stack sizing helpers.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    COND_ZERO             = 3'd0,
    COND_NOT_ZERO         = 3'd1,
    COND_NEGATIVE         = 3'd2,
    COND_POSITIVE         = 3'd3,
    COND_CARRY_SET        = 3'd4,
    COND_CARRY_CLEARED    = 3'd5,
    COND_OVERFLOW_SET     = 3'd6,
    COND_OVERFLOW_CLEARED = 3'd7
  } branch_condition_e;

  localparam int ZERO_FLAG     = 0;
  localparam int POSITIVE_FLAG = 1;
  localparam int CARRY_FLAG    = 2;
  localparam int OVERFLOW_FLAG = 3;

  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    BRANCH = 3'd1,
    CALL   = 3'd2,
    RET    = 3'd3,
    HOLD   = 3'd4
  } seq_op_e;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ras_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Decoder/status-side request bundle and PC/stack status returned by the sequencer.
interface program_sequencer_if
  import program_sequencer_pkg::*;
#(
  parameter int I_ADDR_W  = 12,
  parameter int DATA_W    = 8,
  parameter int RAS_DEPTH = 4
) ();

  logic                              stall;
  logic [I_ADDR_W-1:0]               imar;
  logic [I_ADDR_W-1:0]               address_immediate;
  logic                              jump_branch_select;
  logic                              immediate_select;
  logic                              unconditional_branch;
  logic [DATA_W-1:0]                 status_register;
  branch_condition_e                 branch_condition;
  logic                              pc_relative;
  logic                              call;
  logic                              ret;
  logic [I_ADDR_W-1:0]               pc;
  logic [ras_cnt_w(RAS_DEPTH)-1:0]   ras_depth;
  logic                              ras_overflow;
  logic                              ras_underflow;

  modport master (
    output stall, imar, address_immediate, jump_branch_select, immediate_select,
           unconditional_branch, status_register, branch_condition, pc_relative, call, ret,
    input  pc, ras_depth, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, imar, address_immediate, jump_branch_select, immediate_select,
           unconditional_branch, status_register, branch_condition, pc_relative, call, ret,
    output pc, ras_depth, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/program_sequencer_ras.sv
// LIFO return-address stack; push/pop take effect on the next clock, top entry is combinational.
// Push when full and pop when empty are dropped; the caller decides what that means.
module return_address_stack
  import program_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [W-1:0]                push_dat,
  output logic [W-1:0]                top_dat,
  output logic [ras_cnt_w(DEPTH)-1:0] depth,
  output logic                        full,
  output logic                        empty
);

  localparam int CNT_W = ras_cnt_w(DEPTH);
  localparam int PTR_W = ras_ptr_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] top_cnt;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign depth   = cnt_q;
  assign top_cnt = empty ? '0 : cnt_q - CNT_W'(1);
  assign top_dat = mem[top_cnt[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (push && !full) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push && !pop && !full) begin
      mem[cnt_q[PTR_W-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Next-PC selection (sequential / branch / call / return / stall) with a hardware return stack.
// One-cycle latency: a request in cycle N appears on pc in cycle N+1; stall freezes all state.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int                  I_ADDR_W     = 12,
  parameter int                  INST_W_BYTES = 2,
  parameter int                  DATA_W       = 8,
  parameter int                  RAS_DEPTH    = 4,
  parameter logic [I_ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  program_sequencer_if.slave bus
);

  localparam int CNT_W = ras_cnt_w(RAS_DEPTH);

  logic [I_ADDR_W-1:0] pc_q;
  logic [I_ADDR_W-1:0] pc_nxt;
  logic [I_ADDR_W-1:0] seq_addr;
  logic [I_ADDR_W-1:0] target;
  logic [I_ADDR_W-1:0] branch_addr;
  logic                cond_met;
  logic                branch_taken;
  seq_op_e             op;
  logic [I_ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]    ras_cnt;
  logic                ras_full;
  logic                ras_empty;
  logic                ovf_q;
  logic                unf_q;
  logic                unused_status;

  assign unused_status = ^bus.status_register[DATA_W-1:4];

  assign seq_addr    = pc_q + I_ADDR_W'(INST_W_BYTES);
  assign target      = bus.immediate_select ? bus.address_immediate : bus.imar;
  assign branch_addr = bus.pc_relative ? pc_q + target : target;

  always_comb begin
    cond_met = 1'b0;
    case (bus.branch_condition)
      COND_ZERO:             cond_met =  bus.status_register[ZERO_FLAG];
      COND_NOT_ZERO:         cond_met = !bus.status_register[ZERO_FLAG];
      COND_NEGATIVE:         cond_met = !bus.status_register[POSITIVE_FLAG];
      COND_POSITIVE:         cond_met =  bus.status_register[POSITIVE_FLAG];
      COND_CARRY_SET:        cond_met =  bus.status_register[CARRY_FLAG];
      COND_CARRY_CLEARED:    cond_met = !bus.status_register[CARRY_FLAG];
      COND_OVERFLOW_SET:     cond_met =  bus.status_register[OVERFLOW_FLAG];
      COND_OVERFLOW_CLEARED: cond_met = !bus.status_register[OVERFLOW_FLAG];
      default:               cond_met = 1'b0;
    endcase
  end

  // Calls are always unconditional; only plain conditional branches consult the flags.
  assign branch_taken = bus.jump_branch_select &&
                        (bus.unconditional_branch || bus.call || cond_met);

  always_comb begin
    op = SEQ;
    if (bus.stall)                               op = HOLD;
    else if (bus.ret)                            op = RET;
    else if (bus.call && bus.jump_branch_select) op = CALL;
    else if (branch_taken)                       op = BRANCH;
  end

  always_comb begin
    pc_nxt = seq_addr;
    case (op)
      HOLD:   pc_nxt = pc_q;
      RET:    pc_nxt = ras_empty ? seq_addr : ras_top;
      CALL:   pc_nxt = branch_addr;
      BRANCH: pc_nxt = branch_addr;
      default: pc_nxt = seq_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (op == CALL && ras_full)  ovf_q <= 1'b1;
      if (op == RET  && ras_empty) unf_q <= 1'b1;
    end
  end

  return_address_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (I_ADDR_W)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (op == CALL),
    .pop      (op == RET),
    .push_dat (seq_addr),
    .top_dat  (ras_top),
    .depth    (ras_cnt),
    .full     (ras_full),
    .empty    (ras_empty)
  );

  assign bus.pc            = pc_q;
  assign bus.ras_depth     = ras_cnt;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule
